// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute strobes, counts retired
// instructions and latches unsupported opcodes. Define IMM_ALU_EN to add addi/andi/ori.
module mips_mc_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StRtExe  = 4'd6,
        StRtWb   = 4'd7,
        StBeq    = 4'd8,
        StJump   = 4'd9,
        StIExe   = 4'd10,
        StIWb    = 4'd11
    } state_e;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
`ifdef IMM_ALU_EN
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
`endif

    state_e           state_q, state_d;
    logic             retire;
    logic             illegal_op;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt_q;

    // func is reserved for trap decode; zero is consumed by the PC write-enable logic outside
    logic unused_inputs;
    assign unused_inputs = ^{func, zero};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            StFetch: begin
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                case (opcode)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StRtExe;
                    OpBeq:      state_d = StBeq;
                    OpJ:        state_d = StJump;
`ifdef IMM_ALU_EN
                    OpAddi, OpAndi, OpOri: state_d = StIExe;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = StFetch;
                    end
                endcase
            end
            StMemAdr: state_d = (opcode == OpSw) ? StMemWr : StMemRd;
            StMemRd: begin
                if (mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                retire  = 1'b1;
                state_d = StFetch;
            end
            StMemWr: begin
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end
            end
            StRtExe: state_d = StRtWb;
            StRtWb, StBeq, StJump: begin
                retire  = 1'b1;
                state_d = StFetch;
            end
`ifdef IMM_ALU_EN
            StIExe: state_d = StIWb;
            StIWb: begin
                retire  = 1'b1;
                state_d = StFetch;
            end
`endif
            default: state_d = StFetch;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        case (state_q)
            StFetch: begin
                // PC+4 and IR capture only commit once the fetch data is valid
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            StDecode: begin
                alu_src_b = 2'b11;
            end
            StMemAdr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            StMemRd: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            StMemWr: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            StRtExe: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            StRtWb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            StBeq: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            StJump: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
`ifdef IMM_ALU_EN
            StIExe: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
            end
            StIWb: begin
                reg_write = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (retire) cnt_q <= cnt_q + CNT_W'(1);
            if (illegal_op) illegal_q <= 1'b1;
        end
    end

    assign state     = state_q;
    assign illegal   = illegal_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl; a second 3-bit-counter instance exercises counter wrap.
module tb_mips_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic        illegal;
    logic [15:0] instr_cnt;

    logic        s_pc_write, s_pc_write_cond, s_iord, s_mem_read, s_mem_write, s_ir_write;
    logic        s_mem_to_reg, s_reg_dst, s_reg_write, s_alu_src_a;
    logic [1:0]  s_alu_src_b, s_alu_op, s_pc_source;
    logic [3:0]  s_state;
    logic        s_illegal;
    logic [2:0]  s_instr_cnt;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_cnt = 16'd0;
    logic [2:0]  exp_s;

    always #5 clk = ~clk;

    mips_mc_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .illegal(illegal), .instr_cnt(instr_cnt)
    );

    mips_mc_ctrl #(.CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
        .mem_ready(mem_ready), .pc_write(s_pc_write), .pc_write_cond(s_pc_write_cond),
        .iord(s_iord), .mem_read(s_mem_read), .mem_write(s_mem_write),
        .ir_write(s_ir_write), .mem_to_reg(s_mem_to_reg), .reg_dst(s_reg_dst),
        .reg_write(s_reg_write), .alu_src_a(s_alu_src_a), .alu_src_b(s_alu_src_b),
        .alu_op(s_alu_op), .pc_source(s_pc_source), .state(s_state),
        .illegal(s_illegal), .instr_cnt(s_instr_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; mem_ready = 1'b1; opcode = 6'h00; func = 6'h20; zero = 1'b0;
        #23;
        n_cmp++; if (state !== 4'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
        n_cmp++; if (ir_write !== 1'b1 || pc_write !== 1'b1) begin n_bad++;
            $display("FAIL reset_irpc: got %b%b want 11", ir_write, pc_write); end
        n_cmp++; if (mem_read !== 1'b1 || alu_src_b !== 2'b01 || reg_write !== 1'b0) begin n_bad++;
            $display("FAIL reset_decode: got rd=%b srcb=%b rw=%b want 1 01 0", mem_read, alu_src_b, reg_write); end
        n_cmp++; if (instr_cnt !== 16'd0 || illegal !== 1'b0) begin n_bad++;
            $display("FAIL reset_regs: got cnt=%0d ill=%b want 0 0", instr_cnt, illegal); end
        mem_ready = 1'b0; #1;
        n_cmp++; if (ir_write !== 1'b0 || pc_write !== 1'b0) begin n_bad++;
            $display("FAIL reset_gate: got %b%b want 00", ir_write, pc_write); end
        mem_ready = 1'b1;
        @(posedge clk); #1; rst = 1'b1;
    endtask

    task automatic test_rtype();
        logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        opcode = 6'h00; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (state !== exp_st[i]) begin n_bad++;
                $display("FAIL rtype_state[%0d]: got %0d want %0d", i, state, exp_st[i]); end
            if (i == 0) begin
                n_cmp++; if (ir_write !== 1'b1) begin n_bad++; $display("FAIL rtype_irw: got %b want 1", ir_write); end
            end
            if (i == 2) begin
                n_cmp++; if (alu_op !== 2'b10 || alu_src_a !== 1'b1) begin n_bad++;
                    $display("FAIL rtype_exe: got op=%b a=%b want 10 1", alu_op, alu_src_a); end
            end
            if (i == 3) begin
                n_cmp++; if (reg_write !== 1'b1 || reg_dst !== 1'b1 || mem_to_reg !== 1'b0) begin n_bad++;
                    $display("FAIL rtype_wb: got rw=%b rd=%b m2r=%b want 1 1 0", reg_write, reg_dst, mem_to_reg); end
            end
            if (i < 4) step();
        end
        exp_cnt++;
        n_cmp++; if (instr_cnt !== exp_cnt) begin n_bad++;
            $display("FAIL rtype_cnt: got %0d want %0d", instr_cnt, exp_cnt); end
    endtask

    task automatic test_fetch_stall();
        mem_ready = 1'b0;
        step();
        n_cmp++; if (state !== 4'd0 || ir_write !== 1'b0 || pc_write !== 1'b0 || mem_read !== 1'b1) begin
            n_bad++; $display("FAIL fetch_stall: got st=%0d irw=%b pcw=%b rd=%b want 0 0 0 1",
                              state, ir_write, pc_write, mem_read); end
        mem_ready = 1'b1;
    endtask

    task automatic test_lw();
        logic [3:0] exp_st [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
        opcode = 6'h23; mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mem_ready = (i == 3 || i == 4) ? 1'b0 : 1'b1;
            n_cmp++; if (state !== exp_st[i]) begin n_bad++;
                $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, exp_st[i]); end
            if (i >= 3 && i <= 5) begin
                n_cmp++; if (mem_read !== 1'b1 || iord !== 1'b1) begin n_bad++;
                    $display("FAIL lw_memrd[%0d]: got rd=%b iord=%b want 1 1", i, mem_read, iord); end
            end
            if (i == 6) begin
                n_cmp++; if (reg_write !== 1'b1 || mem_to_reg !== 1'b1 || reg_dst !== 1'b0) begin n_bad++;
                    $display("FAIL lw_wb: got rw=%b m2r=%b rd=%b want 1 1 0", reg_write, mem_to_reg, reg_dst); end
            end
            if (i < 7) step();
        end
        exp_cnt++;
        n_cmp++; if (instr_cnt !== exp_cnt) begin n_bad++;
            $display("FAIL lw_cnt: got %0d want %0d", instr_cnt, exp_cnt); end
    endtask

    task automatic test_sw();
        opcode = 6'h2B; mem_ready = 1'b1;
        step(); step();
        n_cmp++; if (state !== 4'd2 || alu_src_b !== 2'b10 || alu_src_a !== 1'b1) begin n_bad++;
            $display("FAIL sw_memadr: got st=%0d b=%b a=%b want 2 10 1", state, alu_src_b, alu_src_a); end
        step();
        n_cmp++; if (state !== 4'd5 || mem_write !== 1'b1 || iord !== 1'b1 || mem_read !== 1'b0) begin n_bad++;
            $display("FAIL sw_memwr: got st=%0d wr=%b iord=%b rd=%b want 5 1 1 0", state, mem_write, iord, mem_read); end
        step();
        exp_cnt++;
        n_cmp++; if (state !== 4'd0 || instr_cnt !== exp_cnt) begin n_bad++;
            $display("FAIL sw_done: got st=%0d cnt=%0d want 0 %0d", state, instr_cnt, exp_cnt); end
    endtask

    task automatic test_beq();
        opcode = 6'h04; zero = 1'b1; mem_ready = 1'b1;
        step();
        n_cmp++; if (state !== 4'd1 || alu_src_b !== 2'b11) begin n_bad++;
            $display("FAIL beq_decode: got st=%0d b=%b want 1 11", state, alu_src_b); end
        step();
        n_cmp++; if (state !== 4'd8 || pc_write_cond !== 1'b1 || pc_source !== 2'b01 || alu_op !== 2'b01) begin
            n_bad++; $display("FAIL beq_exe: got st=%0d pwc=%b src=%b op=%b want 8 1 01 01",
                              state, pc_write_cond, pc_source, alu_op); end
        step();
        exp_cnt++;
        n_cmp++; if (state !== 4'd0 || instr_cnt !== exp_cnt) begin n_bad++;
            $display("FAIL beq_done: got st=%0d cnt=%0d want 0 %0d", state, instr_cnt, exp_cnt); end
        zero = 1'b0;
    endtask

    task automatic test_jump();
        opcode = 6'h02; mem_ready = 1'b1;
        step(); step();
        n_cmp++; if (state !== 4'd9 || pc_write !== 1'b1 || pc_source !== 2'b10 || mem_read !== 1'b0) begin
            n_bad++; $display("FAIL jump_exe: got st=%0d pcw=%b src=%b rd=%b want 9 1 10 0",
                              state, pc_write, pc_source, mem_read); end
        step();
        exp_cnt++;
        n_cmp++; if (state !== 4'd0 || instr_cnt !== exp_cnt) begin n_bad++;
            $display("FAIL jump_done: got st=%0d cnt=%0d want 0 %0d", state, instr_cnt, exp_cnt); end
    endtask

    task automatic test_illegal();
        opcode = 6'h3F; mem_ready = 1'b1;
        step();
        n_cmp++; if (state !== 4'd1 || illegal !== 1'b0) begin n_bad++;
            $display("FAIL illegal_pre: got st=%0d ill=%b want 1 0", state, illegal); end
        step();
        n_cmp++; if (state !== 4'd0 || illegal !== 1'b1 || instr_cnt !== exp_cnt) begin n_bad++;
            $display("FAIL illegal_set: got st=%0d ill=%b cnt=%0d want 0 1 %0d", state, illegal, instr_cnt, exp_cnt); end
        opcode = 6'h00;
        step(); step(); step(); step();
        exp_cnt++;
        n_cmp++; if (illegal !== 1'b1 || instr_cnt !== exp_cnt) begin n_bad++;
            $display("FAIL illegal_sticky: got ill=%b cnt=%0d want 1 %0d", illegal, instr_cnt, exp_cnt); end
    endtask

    task automatic test_reset_mid();
        opcode = 6'h2B; mem_ready = 1'b1;
        step(); step(); step();
        mem_ready = 1'b0;
        step();
        n_cmp++; if (state !== 4'd5 || mem_write !== 1'b1) begin n_bad++;
            $display("FAIL rstmid_hold: got st=%0d wr=%b want 5 1", state, mem_write); end
        #2 rst = 1'b0;
        #1;
        exp_cnt = 16'd0;
        n_cmp++; if (state !== 4'd0 || mem_write !== 1'b0 || mem_read !== 1'b1) begin n_bad++;
            $display("FAIL rstmid_state: got st=%0d wr=%b rd=%b want 0 0 1", state, mem_write, mem_read); end
        n_cmp++; if (instr_cnt !== 16'd0 || illegal !== 1'b0 || s_instr_cnt !== 3'd0) begin n_bad++;
            $display("FAIL rstmid_regs: got cnt=%0d ill=%b scnt=%0d want 0 0 0", instr_cnt, illegal, s_instr_cnt); end
        @(posedge clk); #1;
        rst = 1'b1; mem_ready = 1'b1;
    endtask

    task automatic test_imm();
        opcode = 6'h08; mem_ready = 1'b1;
`ifdef IMM_ALU_EN
        step(); step();
        n_cmp++; if (state !== 4'd10 || alu_src_a !== 1'b1 || alu_src_b !== 2'b10 || alu_op !== 2'b11) begin
            n_bad++; $display("FAIL addi_exe: got st=%0d a=%b b=%b op=%b want 10 1 10 11",
                              state, alu_src_a, alu_src_b, alu_op); end
        step();
        n_cmp++; if (state !== 4'd11 || reg_write !== 1'b1 || reg_dst !== 1'b0 || mem_to_reg !== 1'b0) begin
            n_bad++; $display("FAIL addi_wb: got st=%0d rw=%b rd=%b m2r=%b want 11 1 0 0",
                              state, reg_write, reg_dst, mem_to_reg); end
        step();
        exp_cnt++;
        n_cmp++; if (state !== 4'd0 || illegal !== 1'b0 || instr_cnt !== exp_cnt) begin n_bad++;
            $display("FAIL addi_done: got st=%0d ill=%b cnt=%0d want 0 0 %0d", state, illegal, instr_cnt, exp_cnt); end
`else
        step(); step();
        n_cmp++; if (state !== 4'd0 || illegal !== 1'b1 || instr_cnt !== exp_cnt) begin n_bad++;
            $display("FAIL addi_illegal: got st=%0d ill=%b cnt=%0d want 0 1 %0d", state, illegal, instr_cnt, exp_cnt); end
`endif
    endtask

    task automatic test_wrap();
        opcode = 6'h02; mem_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step(); step(); step();
            exp_cnt++;
            exp_s = exp_cnt[2:0];
            n_cmp++; if (s_instr_cnt !== exp_s || instr_cnt !== exp_cnt || state !== 4'd0) begin n_bad++;
                $display("FAIL wrap[%0d]: got scnt=%0d cnt=%0d st=%0d want %0d %0d 0",
                         i, s_instr_cnt, instr_cnt, state, exp_s, exp_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_fetch_stall();
        test_lw();
        test_sw();
        test_beq();
        test_jump();
        test_illegal();
        test_reset_mid();
        test_imm();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multi-cycle MIPS control FSM that sequences the instruction decode register (drives its IRWrite) and the shared PC/memory/register-file/ALU datapath.
- Consumes the decoded opcode and func fields; produces per-state datapath strobes and mux selects.
- Sits between the instruction memory handshake and the decode/execute datapath.
- Also keeps a retired-instruction counter and a sticky illegal-opcode flag.

Parameters:
- CNT_W, 16, width of retired-instruction counter instr_cnt.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- opcode  in  6  opcode from decode register
- func  in  6  function field from decode register (unused by FSM, reserved for trap decode)
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory handshake: read data valid / write accepted this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if zero
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IRWrite to decode register
- mem_to_reg  out  1  register write data select: 1=MDR
- reg_dst  out  1  destination register select: 1=rd, 0=rt
- reg_write  out  1  register file write
- alu_src_a  out  1  0=PC, 1=regA
- alu_src_b  out  2  00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- alu_op  out  2  00=add, 01=sub, 10=func-decoded, 11=opcode-decoded immediate
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
- state  out  4  current FSM state
- illegal  out  1  sticky unsupported-opcode flag
- instr_cnt  out  CNT_W  retired-instruction count

Behaviour:
- Moore FSM with a registered state. Outputs are combinational from state, except ir_write and pc_write in FETCH, which are additionally ANDed with mem_ready.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXE=6, RTWB=7, BEQ=8, JUMP=9, IEXE=10, IWB=11.
- Unlisted outputs are 0 in every state.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=pc_write=mem_ready.
  - Holds until mem_ready=1, then goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - 0x23 or 0x2B -> MEMADR
  - 0x00 -> RTEXE
  - 0x04 -> BEQ
  - 0x02 -> JUMP
  - any other opcode -> set illegal, go to FETCH
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next is MEMRD for 0x23, MEMWR for 0x2B.
- MEMRD: mem_read=1, iord=1. Holds until mem_ready, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Retire; next FETCH.
- MEMWR: mem_write=1, iord=1. Holds until mem_ready, then retire; next FETCH.
- RTEXE: alu_src_a=1, alu_src_b=00, alu_op=10. Next RTWB.
- RTWB: reg_write=1, reg_dst=1, mem_to_reg=0. Retire; next FETCH.
- BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Retire; next FETCH.
- JUMP: pc_write=1, pc_source=10. Retire; next FETCH.
- Retire: instr_cnt increments by 1 on the clock edge leaving a retiring state, wrapping from all-ones to 0. Illegal opcodes do not retire.
- illegal: set in DECODE on an unsupported opcode; cleared only by reset.
- Undefined state encodings (12-15) go to FETCH on the next edge.
- Reset: rst low asynchronously forces state=FETCH, instr_cnt=0, illegal=0, at any point including mid-instruction.
  - During reset, outputs show the FETCH decode: mem_read=1, alu_src_b=01, ir_write=pc_write=mem_ready, all others 0.
  - A memory transaction interrupted by reset is abandoned and not retired.
- Latency, mem_ready=1 throughout:
  - lw 5 cycles; sw 4; R-type 4; beq 3; j 3.
  - Each mem_ready-low cycle in FETCH, MEMRD or MEMWR adds one cycle.

Optional Feature:
- IMM_ALU_EN defined:
  - Opcodes 0x08 (addi), 0x0C (andi) and 0x0D (ori) go DECODE -> IEXE -> IWB -> FETCH.
  - IEXE: alu_src_a=1, alu_src_b=10, alu_op=11.
  - IWB: reg_write=1, reg_dst=0, mem_to_reg=0. Retires.
  - Latency 4 cycles.
- Not defined: those opcodes set illegal and return to FETCH; IEXE and IWB are unreachable and treated as undefined states.

Test Plan:
- Reset then release with mem_ready=1, opcode=0x00 -> states 0,1,6,7,0; ir_write=1 in cycle 0; reg_write=1, reg_dst=1 in cycle 3; instr_cnt=1.
- lw (0x23) with mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; mem_read and iord high throughout MEMRD; 7 cycles total.
- beq (0x04), zero=1 -> pc_write_cond=1, pc_source=01, alu_op=01 in state 8; instr_cnt increments; 3 cycles.
- opcode=0x3F -> illegal=1 after DECODE, back to FETCH, instr_cnt unchanged; illegal stays 1 across further valid instructions until rst.
- rst pulsed low mid-MEMWR -> state=0 immediately (asynchronous), mem_write=0, instr_cnt=0, illegal=0.
- Force instr_cnt to 0xFFFF via 65535 j (0x02) instructions, then one more -> instr_cnt wraps to 0x0000. With IMM_ALU_EN, addi (0x08) -> states 0,1,10,11,0.
